hilo_unit: RTL

Sequential HI/LO register stage that sits directly downstream of the combinational signed multiplier and consumes its MultHI, MultLO and Over outputs. A start pulse from the control FSM captures the product, holds the unit busy for a fixed multicycle latency, then commits it to the architectural HI/LO registers with a one-cycle Done pulse. The block also services mthi/mtlo writes and provides HI/LO read values plus an overflow flag to the datapath.

---
 rtl/hilo_pkg.sv | 18 +
 rtl/hilo_latency_ctr.sv | 39 +++
 rtl/hilo_unit.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO register stage.
// Optional feature macro: HILO_OVF_STICKY_EN (sticky overflow flag).
package hilo_pkg;

  // Control states of the commit sequencer
  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StCommit
  } hilo_state_e;

  localparam int unsigned DefaultWidth   = 32;
  localparam int unsigned DefaultLatency = 4;

  // Wide enough for LATENCY-1 with LATENCY up to 15
  localparam int unsigned CtrWidth = 4;

endpackage

// File: rtl/hilo_latency_ctr.sv
// Loadable down-counter that times the multicycle wait before a commit.
// Load has priority over decrement; the count never wraps below zero.
module hilo_latency_ctr
  import hilo_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic [CtrWidth-1:0] load_val_i,
  input  logic                dec_i,
  output logic                at_one_o
);

  localparam logic [CtrWidth-1:0] CtrOne = CtrWidth'(1);

  logic [CtrWidth-1:0] count_d, count_q;

  // Next count: load, else decrement while non-zero
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CtrOne;
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_one_o = (count_q == CtrOne);

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register stage behind the signed multiplier.
// A MultStart captures the product into staging, the unit stays busy for LATENCY cycles, then
// the product is committed to HI/LO with a one-cycle Done pulse. mthi/mtlo writes are accepted
// only while idle.
// Optional feature macro: HILO_OVF_STICKY_EN -- OverFlag becomes sticky and is cleared by ClrOver;
// without it OverFlag tracks the Over value of the latest commit and ClrOver is ignored.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int unsigned LATENCY = DefaultLatency,
  parameter int unsigned WIDTH   = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             MultStart,
  input  logic [WIDTH-1:0] MultHI,
  input  logic [WIDTH-1:0] MultLO,
  input  logic             Over,
  input  logic             MthiWr,
  input  logic             MtloWr,
  input  logic [WIDTH-1:0] WrData,
  input  logic             ClrOver,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic             OverFlag
);

  // Counter holds the cycles still to wait after the start edge
  localparam logic [CtrWidth-1:0] LoadVal = CtrWidth'(LATENCY - 1);

  hilo_state_e state_d, state_q;

  logic [WIDTH-1:0] hi_d, hi_q;
  logic [WIDTH-1:0] lo_d, lo_q;
  logic [WIDTH-1:0] stage_hi_d, stage_hi_q;
  logic [WIDTH-1:0] stage_lo_d, stage_lo_q;
  logic             stage_ovf_d, stage_ovf_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             ovf_d, ovf_q;

  logic ctr_load;
  logic ctr_dec;
  logic ctr_at_one;
  logic commit;
  logic commit_ovf;

  hilo_latency_ctr u_latency_ctr (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .load_i     (ctr_load),
    .load_val_i (LoadVal),
    .dec_i      (ctr_dec),
    .at_one_o   (ctr_at_one)
  );

  // Sequencer next state, register writes and registered status outputs
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    stage_hi_d  = stage_hi_q;
    stage_lo_d  = stage_lo_q;
    stage_ovf_d = stage_ovf_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ctr_load    = 1'b0;
    ctr_dec     = 1'b0;
    commit      = 1'b0;
    commit_ovf  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (MthiWr) begin
          hi_d = WrData;
        end
        if (MtloWr) begin
          lo_d = WrData;
        end
        if (MultStart) begin
          stage_hi_d  = MultHI;
          stage_lo_d  = MultLO;
          stage_ovf_d = Over;
          ctr_load    = 1'b1;
          busy_d      = 1'b1;
          if (LATENCY == 1) begin
            // Single-cycle latency: commit straight from the inputs, overriding any mt write
            state_d    = StCommit;
            hi_d       = MultHI;
            lo_d       = MultLO;
            done_d     = 1'b1;
            commit     = 1'b1;
            commit_ovf = Over;
          end else begin
            state_d = StWait;
          end
        end
      end

      StWait: begin
        ctr_dec = 1'b1;
        if (ctr_at_one) begin
          state_d    = StCommit;
          hi_d       = stage_hi_q;
          lo_d       = stage_lo_q;
          done_d     = 1'b1;
          commit     = 1'b1;
          commit_ovf = stage_ovf_q;
        end
      end

      StCommit: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

`ifdef HILO_OVF_STICKY_EN
  // Sticky flag: a setting commit wins over a simultaneous clear
  always_comb begin
    ovf_d = ovf_q;
    if (commit && commit_ovf) begin
      ovf_d = 1'b1;
    end else if (ClrOver) begin
      ovf_d = 1'b0;
    end
  end
`else
  logic unused_clr_over;
  assign unused_clr_over = ClrOver;

  // Flag follows the overflow bit of the most recent commit
  always_comb begin
    ovf_d = ovf_q;
    if (commit) begin
      ovf_d = commit_ovf;
    end
  end
`endif

  // State and data registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      hi_q        <= '0;
      lo_q        <= '0;
      stage_hi_q  <= '0;
      stage_lo_q  <= '0;
      stage_ovf_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      stage_hi_q  <= stage_hi_d;
      stage_lo_q  <= stage_lo_d;
      stage_ovf_q <= stage_ovf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
    end
  end

  assign HI       = hi_q;
  assign LO       = lo_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign OverFlag = ovf_q;

endmodule
